// File: rtl/ir_edge_timer.sv
// IR receiver front end: synchronises and deglitches the raw line, measures each
// mark/space in prescaled ticks and hands {level, width, eof} tokens downstream.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | between frames; no tokens, waiting for the first falling edge
// ACTIVE | inside a frame; every edge emits a token, long space ends it
module ir_edge_timer #(
    parameter int CLK_DIV      = 50,
    parameter int GLITCH_LEN   = 4,
    parameter int WIDTH_W      = 16,
    parameter int IDLE_TIMEOUT = 10000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ir_in,
    output logic               ir_level,
    output logic               pulse_valid,
    input  logic               pulse_ready,
    output logic               pulse_level,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic               pulse_eof,
    output logic               overflow
);

    localparam int GW = $clog2(GLITCH_LEN + 1);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
    localparam logic [WIDTH_W-1:0] TIMEOUT_W = WIDTH_W'(IDLE_TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic               sync1_q, sync2_q;
    logic [GW-1:0]      filt_cnt_q, filt_cnt_d;
    logic               level_q, level_d;
    logic               level_d1_q;
    logic [PW-1:0]      presc_q, presc_d, presc_eff;
    logic [WIDTH_W-1:0] width_q, width_d;
    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               plevel_q, plevel_d;
    logic [WIDTH_W-1:0] pwidth_q, pwidth_d;
    logic               peof_q, peof_d;
    logic               ovf_q, ovf_d;

    logic               edge_evt, tick, timeout_evt, slot_free;
    logic               tok_evt, tok_level, tok_eof;
    logic [WIDTH_W-1:0] tok_width;

    always_comb begin
        filt_cnt_d = '0;
        level_d    = level_q;
        if (sync2_q != level_q) begin
            if (filt_cnt_q == GW'(GLITCH_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // The edge cycle itself counts as prescaler phase 0, so a segment of N
    // clocks measures exactly N / CLK_DIV ticks.
    assign edge_evt  = level_q ^ level_d1_q;
    assign presc_eff = edge_evt ? '0 : presc_q;
    assign tick      = (presc_eff == PW'(CLK_DIV - 1));
    assign presc_d   = tick ? '0 : presc_eff + 1'b1;

    assign timeout_evt = (state_q == S_ACTIVE) && level_q && !edge_evt
                         && (width_q == TIMEOUT_W);

    always_comb begin
        width_d = width_q;
        if (edge_evt || timeout_evt) begin
            width_d = '0;
        end else if (tick && (width_q != WIDTH_MAX)) begin
            width_d = width_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tok_evt   = 1'b0;
        tok_level = 1'b0;
        tok_width = width_q;
        tok_eof   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (edge_evt && !level_q) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (edge_evt) begin
                    tok_evt   = 1'b1;
                    tok_level = ~level_d1_q;
                end else if (timeout_evt) begin
                    tok_evt   = 1'b1;
                    tok_eof   = 1'b1;
                    tok_width = TIMEOUT_W;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign slot_free = !valid_q || pulse_ready;

    always_comb begin
        valid_d  = valid_q;
        plevel_d = plevel_q;
        pwidth_d = pwidth_q;
        peof_d   = peof_q;
        ovf_d    = ovf_q;
        if (tok_evt && slot_free) begin
            valid_d  = 1'b1;
            plevel_d = tok_level;
            pwidth_d = tok_width;
            peof_d   = tok_eof;
        end else if (valid_q && pulse_ready) begin
            valid_d = 1'b0;
        end
        if (tok_evt && !slot_free) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            filt_cnt_q <= '0;
            level_q    <= 1'b1;
            level_d1_q <= 1'b1;
            presc_q    <= '0;
            width_q    <= '0;
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            plevel_q   <= 1'b0;
            pwidth_q   <= '0;
            peof_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= ir_in;
            sync2_q    <= sync1_q;
            filt_cnt_q <= filt_cnt_d;
            level_q    <= level_d;
            level_d1_q <= level_q;
            presc_q    <= presc_d;
            width_q    <= width_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            plevel_q   <= plevel_d;
            pwidth_q   <= pwidth_d;
            peof_q     <= peof_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ir_level    = level_q;
    assign pulse_valid = valid_q;
    assign pulse_level = plevel_q;
    assign pulse_width = pwidth_q;
    assign pulse_eof   = peof_q;
    assign overflow    = ovf_q;

endmodule
